// File: rtl/mux_pkg.sv
// Shared definitions for the round-robin stream multiplexer family.
package mux_pkg;

  localparam logic MODE_RR    = 1'b0;
  localparam logic MODE_FIXED = 1'b1;

  localparam int STAT_W = 16;

  // Ceiling log2. Small channel counts still get at least one index bit.
  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) res = i + 1;
    end
    if (res == 0) res = 1;
    return res;
  endfunction

endpackage

// File: rtl/rr_arbiter_n.sv
// Combinational round-robin arbiter: the search starts at ptr and wraps modulo N_CH.
module rr_arbiter_n
  import mux_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int SEL_W = clog2(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic [N_CH-1:0]  gnt,
  output logic [SEL_W-1:0] gnt_idx,
  output logic             any_gnt
);

  // The first requester at or after ptr wins. Only one grant is issued.
  always_comb begin
    int c;
    c       = 0;
    gnt     = '0;
    gnt_idx = '0;
    any_gnt = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      c = (int'(ptr) + k) % N_CH;
      if (!any_gnt && req[c]) begin
        gnt[c]  = 1'b1;
        gnt_idx = SEL_W'(c);
        any_gnt = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_rr_nto1.sv
// N-to-1 handshaked stream mux. It arbitrates either round-robin or by fixed select,
// and it has a single registered output stage.
// Optional build macro MUX_RR_STATS_EN adds per-channel saturating transfer counters
// (ports stat_clr, stat_cnt).
module mux_rr_nto1
  import mux_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int WIDTH = 8,
  parameter int SEL_W = clog2(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH*WIDTH-1:0] in_data,
  input  logic [N_CH-1:0]       in_valid,
  output logic [N_CH-1:0]       in_ready,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      fix_sel,
  output logic [WIDTH-1:0]      out_data,
  output logic [SEL_W-1:0]      out_ch,
  output logic                  out_valid,
  input  logic                  out_ready
`ifdef MUX_RR_STATS_EN
  ,
  input  logic                  stat_clr,
  output logic [N_CH*STAT_W-1:0] stat_cnt
`endif
);

  logic [SEL_W-1:0] rr_ptr;
  logic [N_CH-1:0]  rr_gnt;
  logic [SEL_W-1:0] rr_idx;
  logic             rr_any;
  logic [N_CH-1:0]  fix_gnt;
  logic [N_CH-1:0]  gnt;
  logic [SEL_W-1:0] sel_idx;
  logic             any_gnt;
  logic             load;
  logic [N_CH-1:0]  xfer;

  rr_arbiter_n #(
    .N_CH  (N_CH),
    .SEL_W (SEL_W)
  ) u_arb (
    .req     (in_valid),
    .ptr     (rr_ptr),
    .gnt     (rr_gnt),
    .gnt_idx (rr_idx),
    .any_gnt (rr_any)
  );

  // Fixed-select path. An index beyond the last channel matches nothing, so it produces no grant.
  always_comb begin
    fix_gnt = '0;
    for (int i = 0; i < N_CH; i++) begin
      fix_gnt[i] = (int'(fix_sel) == i) && in_valid[i];
    end
  end

  // Choose the grant source for the current mode. A mode change takes effect in the same cycle.
  always_comb begin
    gnt     = rr_gnt;
    sel_idx = rr_idx;
    any_gnt = rr_any;
    if (mode == MODE_FIXED) begin
      gnt     = fix_gnt;
      sel_idx = fix_sel;
      any_gnt = |fix_gnt;
    end
  end

  assign load     = !out_valid || out_ready;
  assign in_ready = (load && !rst) ? gnt : '0;
  assign xfer     = in_valid & in_ready;

  // Output register and round-robin pointer. The pointer follows the last winner in both modes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      rr_ptr    <= '0;
    end else if (load) begin
      if (any_gnt) begin
        out_valid <= 1'b1;
        out_data  <= in_data[int'(sel_idx)*WIDTH +: WIDTH];
        out_ch    <= sel_idx;
        rr_ptr    <= (sel_idx == SEL_W'(N_CH-1)) ? '0 : sel_idx + SEL_W'(1);
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef MUX_RR_STATS_EN
  logic [STAT_W-1:0] cnt_q [N_CH];

  for (genvar g = 0; g < N_CH; g++) begin : g_stat
    // Saturating per-channel transfer count. The clear input has priority over increment.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_q[g] <= '0;
      end else if (stat_clr) begin
        cnt_q[g] <= '0;
      end else if (xfer[g] && (cnt_q[g] != {STAT_W{1'b1}})) begin
        cnt_q[g] <= cnt_q[g] + STAT_W'(1);
      end
    end
    assign stat_cnt[g*STAT_W +: STAT_W] = cnt_q[g];
  end
`else
  logic unused_xfer;
  assign unused_xfer = ^xfer;
`endif

endmodule

// File: doc/mux_rr_nto1.md
Name: mux_rr_nto1

Overview:
Parametrised N-to-1 stream multiplexer: the registered, handshaked successor to the 2:1 and 4:1 select muxes.
- Each input channel carries WIDTH-bit data with valid/ready.
- The block arbitrates in one of two modes: round-robin, or fixed select driven by an external select input.
- The winner is presented through one output register stage with valid/ready backpressure.
- Sits between multiple ALU or operand sources and a single downstream consumer.

Parameters:
N_CH, 4, number of input channels (>=2)
WIDTH, 8, data width per channel
SEL_W, $clog2(N_CH), width of channel index (derived; not overridden)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous reset, active-high
in_data  input  N_CH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
in_valid  input  N_CH  per-channel data valid
in_ready  output  N_CH  per-channel accept (combinational)
mode  input  1  0 = round-robin, 1 = fixed select
fix_sel  input  SEL_W  channel selected when mode=1
out_data  output  WIDTH  registered selected data
out_ch  output  SEL_W  registered index of the channel that produced out_data
out_valid  output  1  registered output valid
out_ready  input  1  downstream accept

Behaviour:
- Reset (async, rst=1): out_valid=0, out_data=0, out_ch=0, rr_ptr=0. in_ready is all-zero while rst is high.
- Load enable: load = !out_valid | out_ready. The output register is free, or is emptying this cycle.
- Round-robin mode (mode=0):
  - Grant goes to the first channel with in_valid set, searching rr_ptr, rr_ptr+1, ... with modulo-N_CH wrap.
  - At most one grant per cycle.
- Fixed mode (mode=1):
  - Grant goes to fix_sel only if in_valid[fix_sel]=1.
  - fix_sel >= N_CH means no grant.
  - No other channel is ever granted.
- in_ready[i] = load & grant[i]. A transfer on channel i occurs when in_valid[i] & in_ready[i].
- On a transfer, at the next edge:
  - out_data <= channel data; out_ch <= i; out_valid <= 1.
  - rr_ptr <= (i+1) mod N_CH. This applies in both modes, so a return to RR resumes after the last winner.
- With load=1 and no grant: out_valid <= 0; out_data and out_ch hold their previous values.
- With load=0 (out_valid=1, out_ready=0): out_data, out_ch and out_valid hold stable; all in_ready=0.
- Latency: 1 cycle from input transfer to out_valid.
- Throughput: 1 word per cycle when out_ready is held high.
- Simultaneous pop and push (out_valid=1, out_ready=1, grant present): the register is replaced in the same edge with no bubble.
- Changes to mode or fix_sel take effect on the arbitration in the same cycle. A word already held in the register is unaffected.
- rr_ptr wraps from N_CH-1 to 0.
- Fairness: with all channels valid and no backpressure, grants go 0,1,...,N_CH-1,0,...
- Reset asserted mid-transfer: the output word is discarded and the state returns to the reset values immediately.

Optional Feature:
MUX_RR_STATS_EN
- Defined:
  - Adds output port stat_cnt (N_CH*16): one 16-bit saturating transfer counter per channel.
  - A counter increments on each transfer from its channel and saturates at 16'hFFFF.
  - Adds input stat_clr (1), a synchronous clear of all counters that has priority over increment.
  - Counters reset to 0 on rst.
- Undefined: neither port exists and no counter logic is generated.

Decomposition:
- Shared package mux_pkg holds:
  - mode encodings MODE_RR=1'b0, MODE_FIXED=1'b1
  - STAT_W=16
  - a clog2 helper function
- One sub-module, rr_arbiter_n:
  - inputs: req[N_CH], ptr[SEL_W]
  - outputs: one-hot gnt[N_CH], gnt_idx[SEL_W], any_gnt
  - purely combinational, reusable by other arbitrated blocks.
- The top level instantiates rr_arbiter_n, the fixed-select path, the output register and the optional counters.

Test Plan (N_CH=4, WIDTH=8):
- Reset: assert rst mid-stream with out_valid=1 -> out_valid, out_data and out_ch are 0 immediately, and in_ready=4'b0000 while rst is high.
- RR fairness: in_valid=4'b1111 with data 8'hA0..8'hA3 and out_ready=1 -> out_ch sequence 0,1,2,3,0 with out_data A0,A1,A2,A3,A0 on consecutive cycles.
- Sparse RR with wrap: after a grant to channel 3, in_valid=4'b0101 -> next grant is channel 0, then channel 2.
- Backpressure: hold out_ready=0 for 3 cycles with out_valid=1 -> out_data is stable and in_ready=0; release -> the next word follows on the very next edge with no bubble.
- Fixed mode: mode=1, fix_sel=2, in_valid=4'b1111 -> only channel 2 is granted every cycle; fix_sel=2 with in_valid[2]=0 -> out_valid drops to 0.
- MUX_RR_STATS_EN: 70000 transfers on channel 1 -> stat_cnt[1] reads 16'hFFFF; stat_clr pulse -> all counters read 0 on the next cycle.
